// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands/opcode toward the ALU, registered result and flags back.
// The datapath side uses the master modport, the ALU itself uses slave.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Result;
  logic             Zero_Flag;
  logic             Carry;
  logic             Overflow;
  logic             out_valid;

  modport master (
    output in_valid,
    output ALUControl,
    output A,
    output B,
    input  Result,
    input  Zero_Flag,
    input  Carry,
    input  Overflow,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  ALUControl,
    input  A,
    input  B,
    output Result,
    output Zero_Flag,
    output Carry,
    output Overflow,
    output out_valid
  );
endinterface

// File: rtl/alu.sv
// Registered MIPS-style ALU: logic ops, add/sub and signed/unsigned set-less-than
// sharing one adder; result and flags are captured together with one cycle of latency.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_raw;
  logic [WIDTH-1:0] result_nxt;
  logic             carry_nxt;
  logic             overflow_nxt;
  logic             zero_nxt;

  // Compares and SUB all run A + ~B + 1 through the same adder as ADD.
  always_comb begin
    sub_mode = (bus.ALUControl == OP_SLTU) ||
               (bus.ALUControl == OP_SUB)  ||
               (bus.ALUControl == OP_SLT);
    b_eff    = sub_mode ? ~bus.B : bus.B;
    sum_full = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    sum      = sum_full[WIDTH-1:0];
    cout     = sum_full[WIDTH];
    ovf_raw  = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
  end

  always_comb begin
    result_nxt   = '0;
    carry_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    case (bus.ALUControl)
      OP_AND:  result_nxt = bus.A & bus.B;
      OP_OR:   result_nxt = bus.A | bus.B;
      OP_XOR:  result_nxt = bus.A ^ bus.B;
      OP_NOR:  result_nxt = ~(bus.A | bus.B);
      OP_ADD: begin
        result_nxt   = sum;
        carry_nxt    = cout;
        overflow_nxt = ovf_raw;
      end
      OP_SUB: begin
        result_nxt   = sum;
        carry_nxt    = cout;
        overflow_nxt = ovf_raw;
      end
      // No-borrow means A >= B unsigned, so less-than is its complement.
      OP_SLTU: begin
        result_nxt = {{(WIDTH-1){1'b0}}, ~cout};
        carry_nxt  = cout;
      end
      // Sign of the difference is wrong exactly when the subtraction overflowed.
      OP_SLT: begin
        result_nxt = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
        carry_nxt  = cout;
      end
      default: result_nxt = '0;
    endcase
    zero_nxt = (result_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Result    <= '0;
      bus.Zero_Flag <= 1'b0;
      bus.Carry     <= 1'b0;
      bus.Overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Result    <= result_nxt;
        bus.Zero_Flag <= zero_nxt;
        bus.Carry     <= carry_nxt;
        bus.Overflow  <= overflow_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations come from a behavioural model when operands
// are driven and are compared when out_valid shows the registered result.
module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  exp_t last_out;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    logic [32:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b011: e.res = a ^ b;
      3'b100: e.res = ~(a | b);
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        e.res = t[31:0];
        e.c = t[32];
        s = sa + sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        e.res = a - b;
        e.c = (a >= b);
        s = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b101: begin
        e.res = (a < b) ? 32'd1 : 32'd0;
        e.c = (a >= b);
      end
      default: begin
        e.res = (sa < sb) ? 32'd1 : 32'd0;
        e.c = (a >= b);
      end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    sb_q.push_back(model(op, a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.ALUControl = 3'($urandom_range(0, 7));
      bus.A = $urandom;
      bus.B = $urandom;
    end
  endtask

  // Monitor: compare on out_valid, otherwise expect the previous values to hold.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", bus.Result, e.res);
          chk("zero", 32'(bus.Zero_Flag), 32'(e.z));
          chk("carry", 32'(bus.Carry), 32'(e.c));
          chk("overflow", 32'(bus.Overflow), 32'(e.v));
          last_out = e;
        end
      end else begin
        chk("hold_result", bus.Result, last_out.res);
        chk("hold_flags", {29'd0, bus.Zero_Flag, bus.Carry, bus.Overflow},
            {29'd0, last_out.z, last_out.c, last_out.v});
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.ALUControl = 3'b000;
    bus.A = '0;
    bus.B = '0;
    last_out = '{res: 32'd0, z: 1'b0, c: 1'b0, v: 1'b0};
    #12;
    chk("rst_result", bus.Result, 32'd0);
    chk("rst_flags", {28'd0, bus.Zero_Flag, bus.Carry, bus.Overflow, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(3'b000, 32'h14071757, 32'h14071758);
    drive(3'b001, 32'h14071757, 32'h14071758);
    drive(3'b010, 32'h14071757, 32'h14071758);
    drive(3'b110, 32'h14071757, 32'h14071758);
    drive(3'b111, 32'h14071757, 32'h14071758);
    drive(3'b111, 32'h14071758, 32'h14071757);
    idle(2);
    drive(3'b111, 32'h80000000, 32'h00000001);
    drive(3'b101, 32'h80000000, 32'h00000001);
    drive(3'b110, 32'h80000000, 32'h00000001);
    drive(3'b010, 32'h7FFFFFFF, 32'h00000001);
    drive(3'b110, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(3'b011, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drive(3'b010, 32'hFFFFFFFF, 32'h00000001);
    drive(3'b101, 32'h00000001, 32'hFFFFFFFF);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      drive(3'($urandom_range(0, 7)), a, b);
    end
    idle(2);

    // Three-op stream, then a reset pulse between edges.
    drive(3'b010, 32'h00000005, 32'h00000007);
    drive(3'b110, 32'h00000009, 32'h00000003);
    drive(3'b001, 32'h000000F0, 32'h0000000F);
    idle(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", bus.Result, 32'd0);
    chk("async_rst_flags", {28'd0, bus.Zero_Flag, bus.Carry, bus.Overflow, bus.out_valid}, 32'd0);
    sb_q.delete();
    last_out = '{res: 32'd0, z: 1'b0, c: 1'b0, v: 1'b0};
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b111, 32'hFFFFFFFF, 32'h00000000);
    idle(3);

    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
